tick_scheduler: RTL

Run/stop controller and programmable modulus sequencer for the three-stage tick chain on the IceStick: an 8-bit prescaler, a 5-bit middle stage and a 10-bit slow stage. It generates the one-cycle stage enables (TICK0/1/2) that drive the J3 strobes. Stage moduli are reconfigured through a valid/ready handshake. Changes made while running take effect only at a slow-stage wrap, so no tick period is ever truncated.

---
 rtl/tick_sched_pkg.sv | 27 ++
 rtl/tick_stage.sv | 50 +++++
 rtl/tick_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the three-stage tick scheduler.
// Holds the run-state enum, the reset-default moduli and the modulus-to-compare mapping.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    S_STOP = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_e;

  localparam int unsigned DEF_M0 = 32'd103;
  localparam int unsigned DEF_M1 = 32'd32;
  localparam int unsigned DEF_M2 = 32'd1000;

  // A modulus of 0 means 2^width, so its last count value is all-ones.
  function automatic logic [15:0] mod_to_cmp(input logic [15:0] modulus,
                                             input int unsigned width);
    logic [15:0] all_ones;
    all_ones = 16'((32'd1 << width) - 32'd1);
    if (modulus == 16'd0) begin
      mod_to_cmp = all_ones;
    end else begin
      mod_to_cmp = modulus - 16'd1;
    end
  endfunction

endpackage

// File: rtl/tick_stage.sv
// One modulus counter of the tick chain: counts on enable, wraps at modulus-1.
// The wrap strobe depends only on the registered count, the enable and the modulus.
module tick_stage
  import tick_sched_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         clear,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] cmp_s;

  assign cmp_s = W'(mod_to_cmp(16'(modulus), W));
  assign wrap  = enable && (count_q == cmp_s);
  assign count = count_q;

  // Next count: clear dominates, then wrap, then increment.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Run/stop controller for the prescaler / middle / slow tick chain.
// New moduli taken while counting are parked in a shadow copy until the next slow-stage wrap.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned W0     = 8,
  parameter int unsigned W1     = 5,
  parameter int unsigned W2     = 10,
  parameter int unsigned DEF_M0 = tick_sched_pkg::DEF_M0,
  parameter int unsigned DEF_M1 = tick_sched_pkg::DEF_M1,
  parameter int unsigned DEF_M2 = tick_sched_pkg::DEF_M2
) (
  input  logic          CLK,
  input  logic          RESETN,
  input  logic          START,
  input  logic          STOP,
  input  logic          CFG_VALID,
  output logic          CFG_READY,
  input  logic [W0-1:0] CFG_M0,
  input  logic [W1-1:0] CFG_M1,
  input  logic [W2-1:0] CFG_M2,
  output logic          TICK0,
  output logic          TICK1,
  output logic          TICK2,
  output logic          RUNNING,
  output logic [W2-1:0] COUNT2
);

  localparam int unsigned MW = W0 + W1 + W2;
  localparam logic [MW-1:0] DEF_MODS = {W2'(DEF_M2), W1'(DEF_M1), W0'(DEF_M0)};

  state_e          state_q;
  state_e          state_d;
  logic [MW-1:0]   live_q;
  logic [MW-1:0]   live_d;
  logic [MW-1:0]   shad_q;
  logic [MW-1:0]   shad_d;
  logic [MW-1:0]   cfg_s;
  logic            running_s;
  logic            ready_s;
  logic            accept_s;
  logic            clear_s;
  logic            tick0_s;
  logic            tick1_s;
  logic            tick2_s;
  logic [W0-1:0]   count0_s;
  logic [W1-1:0]   count1_s;
  logic [W2-1:0]   count2_s;
  logic            unused_counts_s;

  assign cfg_s     = {CFG_M2, CFG_M1, CFG_M0};
  assign running_s = (state_q != S_STOP);
  assign ready_s   = (state_q != S_PEND);
  assign accept_s  = CFG_VALID && ready_s;
  // Leaving RUN/PEND zeroes every stage on the same edge; in STOP they already sit at 0.
  assign clear_s   = running_s && STOP;

  // Only the slow count is exported; the lower counts are internal.
  assign unused_counts_s = ^{count0_s, count1_s};

  tick_stage #(.W(W0)) u_stage0 (
    .clk     (CLK),
    .rst_n   (RESETN),
    .enable  (running_s),
    .clear   (clear_s),
    .modulus (live_q[W0-1:0]),
    .count   (count0_s),
    .wrap    (tick0_s)
  );

  tick_stage #(.W(W1)) u_stage1 (
    .clk     (CLK),
    .rst_n   (RESETN),
    .enable  (tick0_s),
    .clear   (clear_s),
    .modulus (live_q[W0+W1-1:W0]),
    .count   (count1_s),
    .wrap    (tick1_s)
  );

  tick_stage #(.W(W2)) u_stage2 (
    .clk     (CLK),
    .rst_n   (RESETN),
    .enable  (tick1_s),
    .clear   (clear_s),
    .modulus (live_q[MW-1:W0+W1]),
    .count   (count2_s),
    .wrap    (tick2_s)
  );

  // Next state and moduli; STOP outranks START and the RUN->PEND move, but never loses a config.
  always_comb begin
    state_d = state_q;
    live_d  = live_q;
    shad_d  = shad_q;
    case (state_q)
      S_STOP: begin
        if (accept_s) begin
          live_d = cfg_s;
          shad_d = cfg_s;
        end else begin
          live_d = live_q;
          shad_d = shad_q;
        end
        if (STOP) begin
          state_d = S_STOP;
        end else if (START) begin
          state_d = S_RUN;
        end else begin
          state_d = S_STOP;
        end
      end
      S_RUN: begin
        if (STOP) begin
          state_d = S_STOP;
          if (accept_s) begin
            live_d = cfg_s;
            shad_d = cfg_s;
          end else begin
            live_d = live_q;
            shad_d = shad_q;
          end
        end else if (accept_s) begin
          state_d = S_PEND;
          shad_d  = cfg_s;
        end else begin
          state_d = S_RUN;
        end
      end
      S_PEND: begin
        // Shadow goes live at the slow wrap, or right away when stopping.
        if (STOP) begin
          state_d = S_STOP;
          live_d  = shad_q;
        end else if (tick2_s) begin
          state_d = S_RUN;
          live_d  = shad_q;
        end else begin
          state_d = S_PEND;
        end
      end
      default: begin
        state_d = S_STOP;
        live_d  = DEF_MODS;
        shad_d  = DEF_MODS;
      end
    endcase
  end

  // Control state, live and shadow moduli.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_STOP;
      live_q  <= DEF_MODS;
      shad_q  <= DEF_MODS;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      shad_q  <= shad_d;
    end
  end

  assign CFG_READY = ready_s;
  assign RUNNING   = running_s;
  assign TICK0     = tick0_s;
  assign TICK1     = tick1_s;
  assign TICK2     = tick2_s;
  assign COUNT2    = count2_s;

endmodule
